// File: rtl/fnd_pkg.sv
// Shared types and font table for the FND scan display.
// Leading-zero blanking is selected with FND_LZ_BLANK_EN.
package fnd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } conv_state_e;

  typedef logic [1:0] digit_idx_t;
  typedef logic [3:0] bcd_t;

  // Active-low segments {dp,g,f,e,d,c,b,a}
  localparam logic [7:0] FONT_LUT [10] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };
  localparam logic [7:0] FONT_BLANK = 8'hFF;

  function automatic logic [7:0] font_of(bcd_t d);
    if (d > 4'd9) return FONT_BLANK;
    return FONT_LUT[d];
  endfunction

endpackage

// File: rtl/fnd_scan_display_if.sv
// Number input and FND pin bundle.
// master drives number; slave drives the FND pins.
interface fnd_scan_display_if #(
  parameter int NUM_WIDTH = 14
);
  logic [NUM_WIDTH-1:0] number;
  logic [3:0]           fndCom;
  logic [7:0]           fndFont;

  modport master (
    output number,
    input  fndCom,
    input  fndFont
  );

  modport slave (
    input  number,
    output fndCom,
    output fndFont
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift per cycle,
// result held on bcd while done is high.
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int NUM_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [NUM_WIDTH-1:0] bin,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          bcd
);

  localparam int SW = 16 + NUM_WIDTH;
  localparam int CW = $clog2(NUM_WIDTH + 1);

  conv_state_e   r_state, w_state_nxt;
  logic [SW-1:0] r_sh, w_sh_nxt, w_adj;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  always_comb begin
    w_adj = r_sh;
    for (int i = 0; i < 4; i++) begin
      if (r_sh[NUM_WIDTH+4*i +: 4] >= 4'd5)
        w_adj[NUM_WIDTH+4*i +: 4] =
          r_sh[NUM_WIDTH+4*i +: 4] + 4'd3;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sh_nxt    = r_sh;
    w_cnt_nxt   = r_cnt;
    busy        = 1'b0;
    done        = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          w_sh_nxt    = {16'd0, bin};
          w_cnt_nxt   = '0;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        w_sh_nxt  = {w_adj[SW-2:0], 1'b0};
        w_cnt_nxt = r_cnt + CW'(1);
        if (r_cnt == CW'(NUM_WIDTH - 1))
          w_state_nxt = DONE;
      end
      DONE: begin
        busy        = 1'b1;
        done        = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sh    <= w_sh_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign bcd = r_sh[SW-1 -: 16];

endmodule

// File: rtl/fnd_scan_display.sv
// 4-digit common-anode FND driver with saturating BCD conversion.
// FND_LZ_BLANK_EN enables leading-zero blanking of digits 3..1.
module fnd_scan_display
  import fnd_pkg::*;
#(
  parameter int CLK_FREQ_HZ  = 100_000_000,
  parameter int SCAN_FREQ_HZ = 1_000,
  parameter int NUM_WIDTH    = 14,
  parameter int MAX_VALUE    = 9999
) (
  input logic               clk,
  input logic               reset,
  fnd_scan_display_if.slave bus
);

  localparam int DIV = CLK_FREQ_HZ / SCAN_FREQ_HZ;
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [NUM_WIDTH-1:0] MAX_N =
    NUM_WIDTH'(MAX_VALUE);

  logic [NUM_WIDTH-1:0] w_sat, r_last;
  logic                 w_start, w_busy, w_done;
  logic [15:0]          w_bcd, r_shadow, w_shadow_nxt;
  logic [DW-1:0]        r_div;
  logic                 w_tick;
  digit_idx_t           r_idx, w_idx_nxt;
  bcd_t                 w_digit;
  logic [3:0]           w_blank;
  logic [3:0]           r_com;
  logic [7:0]           r_font, w_font;

  assign w_sat   = (bus.number > MAX_N) ? MAX_N : bus.number;
  assign w_start = !w_busy && (w_sat != r_last);

  bin2bcd_seq #(
    .NUM_WIDTH(NUM_WIDTH)
  ) u_conv (
    .clk   (clk),
    .reset (reset),
    .start (w_start),
    .bin   (w_sat),
    .busy  (w_busy),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last   <= '0;
      r_shadow <= '0;
    end else begin
      if (w_start) r_last <= w_sat;
      r_shadow <= w_shadow_nxt;
    end
  end

  // A tick coinciding with a shadow load shows the new value
  assign w_shadow_nxt = w_done ? w_bcd : r_shadow;
  assign w_tick       = (r_div == DW'(DIV - 1));
  assign w_idx_nxt    = r_idx + 2'd1;
  assign w_digit      = w_shadow_nxt[{w_idx_nxt, 2'b00} +: 4];

`ifdef FND_LZ_BLANK_EN
  logic w_z3, w_z2, w_z1;
  assign w_z3    = (w_shadow_nxt[15:12] == 4'd0);
  assign w_z2    = (w_shadow_nxt[11:8] == 4'd0);
  assign w_z1    = (w_shadow_nxt[7:4] == 4'd0);
  assign w_blank = {w_z3, w_z3 & w_z2,
                    w_z3 & w_z2 & w_z1, 1'b0};
`else
  assign w_blank = 4'b0000;
`endif

  assign w_font = w_blank[w_idx_nxt] ? FONT_BLANK
                                     : font_of(w_digit);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div  <= '0;
      r_idx  <= '0;
      r_com  <= 4'b1111;
      r_font <= FONT_BLANK;
    end else begin
      r_div <= w_tick ? '0 : r_div + DW'(1);
      if (w_tick) begin
        r_idx  <= w_idx_nxt;
        r_com  <= ~(4'b0001 << w_idx_nxt);
        r_font <= w_font;
      end
    end
  end

  assign bus.fndCom  = r_com;
  assign bus.fndFont = r_font;

endmodule

// File: tb/tb_fnd_scan_display.sv
// Scoreboard bench for fnd_scan_display (DIV=4).
// Honors FND_LZ_BLANK_EN for the blanking vectors.
module tb_fnd_scan_display;

  typedef struct packed {
    logic [3:0] com;
    logic [7:0] font;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  fnd_scan_display_if #(.NUM_WIDTH(14)) bus ();

  fnd_scan_display #(
    .CLK_FREQ_HZ  (1000),
    .SCAN_FREQ_HZ (250),
    .NUM_WIDTH    (14),
    .MAX_VALUE    (9999)
  ) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus.slave)
  );

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: every digit advance is compared with the next entry
  initial begin
    logic [3:0] prev;
    exp_t e;
    prev = 4'b1111;
    forever begin
      @(negedge clk);
      if (bus.fndCom !== prev && q.size() > 0) begin
        e = q.pop_front();
        chk("scan", {20'd0, bus.fndCom, bus.fndFont},
            {20'd0, e.com, e.font});
      end
      prev = bus.fndCom;
    end
  end

  task automatic scan_check(input logic [7:0] f0, f1, f2, f3,
                            input int rounds);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.fndCom === 4'b0111) found = 1'b1;
    end
    if (!found) begin
      chk("scan_sync", 32'd0, 32'd1);
      return;
    end
    #1;
    for (int r = 0; r < rounds; r++) begin
      q.push_back('{4'b1110, f0});
      q.push_back('{4'b1101, f1});
      q.push_back('{4'b1011, f2});
      q.push_back('{4'b0111, f3});
    end
    for (int i = 0; i < rounds * 16 + 20 && q.size() > 0; i++)
      @(posedge clk);
    #1;
    if (q.size() > 0) begin
      chk("scan_timeout", q.size(), 0);
      q.delete();
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.number = 14'd1234;
    #23;
    chk("rst_com", {28'd0, bus.fndCom}, 32'hF);
    chk("rst_font", {24'd0, bus.fndFont}, 32'hFF);

    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(15);
    chk("lat15", {16'd0, dut.r_shadow}, 32'h0000);
    wait_cyc(1);
    chk("lat16", {16'd0, dut.r_shadow}, 32'h1234);

    scan_check(8'h99, 8'hB0, 8'hA4, 8'hF9, 4);

    @(negedge clk);
    bus.number = 14'd12000;
    wait_cyc(20);
    chk("sat", {16'd0, dut.r_shadow}, 32'h9999);
    scan_check(8'h90, 8'h90, 8'h90, 8'h90, 1);

    // Change input mid-shift: first result still wins
    @(negedge clk);
    bus.number = 14'd1234;
    repeat (6) @(posedge clk);
    @(negedge clk);
    bus.number = 14'd5678;
    wait_cyc(9);
    chk("mid15", {16'd0, dut.r_shadow}, 32'h9999);
    wait_cyc(1);
    chk("mid16", {16'd0, dut.r_shadow}, 32'h1234);
    wait_cyc(15);
    chk("mid31", {16'd0, dut.r_shadow}, 32'h1234);
    wait_cyc(1);
    chk("mid32", {16'd0, dut.r_shadow}, 32'h5678);
    scan_check(8'h80, 8'hF8, 8'h82, 8'h92, 1);

    @(negedge clk);
    bus.number = 14'd7;
    wait_cyc(20);
`ifdef FND_LZ_BLANK_EN
    scan_check(8'hF8, 8'hFF, 8'hFF, 8'hFF, 1);
`else
    scan_check(8'hF8, 8'hC0, 8'hC0, 8'hC0, 1);
`endif
    @(negedge clk);
    bus.number = 14'd0;
    wait_cyc(20);
`ifdef FND_LZ_BLANK_EN
    scan_check(8'hC0, 8'hFF, 8'hFF, 8'hFF, 1);
`else
    scan_check(8'hC0, 8'hC0, 8'hC0, 8'hC0, 1);
`endif

    // Reset pulse while converting
    @(negedge clk);
    bus.number = 14'd4321;
    wait_cyc(20);
    @(negedge clk);
    bus.number = 14'd8765;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst2_com", {28'd0, bus.fndCom}, 32'hF);
    chk("rst2_font", {24'd0, bus.fndFont}, 32'hFF);
    chk("rst2_shadow", {16'd0, dut.r_shadow}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(16);
    chk("rst2_lat", {16'd0, dut.r_shadow}, 32'h8765);
    scan_check(8'h92, 8'h82, 8'hF8, 8'h80, 1);

    chk("q_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
